// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants and encodings for the FIFO write arbiter and its round-robin sub-arbiter.
package fifo_wr_arbiter_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 16;
    localparam int unsigned DEF_CNT_W = $clog2(DEF_DEPTH) + 1;

    // Occupancy counter width able to hold 0..depth inclusive
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Encoded so that a cleared register means "producer 1 last", giving producer 0 the first tie
    typedef enum logic {
        LAST_P1 = 1'b0,
        LAST_P0 = 1'b1
    } last_gnt_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with grant enable, synchronous clear and last-grant memory.
module rr_arb2
    import fifo_wr_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       clr_i,
    output logic [1:0] gnt_c
);

    last_gnt_e last_q, last_d;

    always_comb begin
        gnt_c = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_c = 2'b01;
                2'b10:   gnt_c = 2'b10;
                2'b11:   gnt_c = (last_q == LAST_P1) ? 2'b01 : 2'b10;
                default: gnt_c = 2'b00;
            endcase
        end
    end

    // History only moves on a granted cycle
    always_comb begin
        last_d = last_q;
        if (clr_i)         last_d = LAST_P1;
        else if (gnt_c[0]) last_d = LAST_P0;
        else if (gnt_c[1]) last_d = LAST_P1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= LAST_P1;
        else     last_q <= last_d;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter and occupancy controller for an external synchronous FIFO:
// two producers share the write port, one consumer reads, with flush and sticky error flags.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0,
    input  logic                   req1,
    input  logic [WIDTH-1:0]       data0,
    input  logic [WIDTH-1:0]       data1,
    output logic                   gnt0,
    output logic                   gnt1,
    input  logic                   rd_req,
    output logic                   rd_valid,
    input  logic                   flush,
    output logic [WIDTH-1:0]       fifo_data_in,
    output logic                   fifo_en_write,
    output logic                   fifo_en_read,
    output logic                   fifo_reset,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   ovf_err,
    output logic                   udf_err
);

    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             rd_valid_q, rd_valid_d;
    logic             fifo_rst_q, fifo_rst_d;
    logic             blocked;
    logic [1:0]       gnt;
    logic             wr_en;
    logic             rd_en;

    // Nothing moves while the FIFO is being cleared or about to be
    assign blocked = flush | fifo_rst_q;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (reset),
        .req_i ({req1, req0}),
        .en_i  (~full_q & ~blocked),
        .clr_i (flush),
        .gnt_c (gnt)
    );

    assign wr_en = gnt[0] | gnt[1];
    assign rd_en = rd_req & ~empty_q & ~blocked;

    always_comb begin
        fifo_data_in = '0;
        if (gnt[0])      fifo_data_in = data0;
        else if (gnt[1]) fifo_data_in = data1;
    end

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ovf_d      = ovf_q | ((req0 | req1) & full_q);
        udf_d      = udf_q | (rd_req & empty_q);
        rd_valid_d = rd_en;
        fifo_rst_d = flush;
        if (flush) begin
            count_d    = '0;
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
            rd_valid_d = 1'b0;
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            fifo_rst_q <= 1'b1;
        end else begin
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            rd_valid_q <= rd_valid_d;
            fifo_rst_q <= fifo_rst_d;
        end
    end

    assign gnt0          = gnt[0];
    assign gnt1          = gnt[1];
    assign fifo_en_write = wr_en;
    assign fifo_en_read  = rd_en;
    assign fifo_reset    = fifo_rst_q;
    assign rd_valid      = rd_valid_q;
    assign count         = count_q;
    assign full          = full_q;
    assign empty         = empty_q;
    assign ovf_err       = ovf_q;
    assign udf_err       = udf_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter with hand-computed expectations.
module tb_fifo_wr_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0, req1, rd_req, flush;
    logic [WIDTH-1:0] data0, data1;
    logic             gnt0, gnt1, rd_valid;
    logic [WIDTH-1:0] fifo_data_in;
    logic             fifo_en_write, fifo_en_read, fifo_reset;
    logic [4:0]       count;
    logic             full, empty, ovf_err, udf_err;

    int n_vec  = 0;
    int n_miss = 0;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .data0        (data0),
        .data1        (data1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .rd_req       (rd_req),
        .rd_valid     (rd_valid),
        .flush        (flush),
        .fifo_data_in (fifo_data_in),
        .fifo_en_write(fifo_en_write),
        .fifo_en_read (fifo_en_read),
        .fifo_reset   (fifo_reset),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .ovf_err      (ovf_err),
        .udf_err      (udf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0; flush = 1'b0;
        data0 = '0; data1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic write_n(input int n);
        req0 = 1'b1;
        for (int i = 0; i < n; i++) step();
        req0 = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        chk("rst_udf", 32'(udf_err), 32'd0);
        chk("rst_fifo_reset", 32'(fifo_reset), 32'd1);
        step();
        reset = 1'b0;
        req0 = 1'b1; data0 = 8'h11;
        settle();
        chk("post_rst_fifo_reset", 32'(fifo_reset), 32'd1);
        chk("post_rst_gnt0_blocked", 32'(gnt0), 32'd0);
        step();
        chk("post_rst_fifo_reset_drop", 32'(fifo_reset), 32'd0);
        chk("post_rst_req_ignored", 32'(count), 32'd0);

        // single write
        data0 = 8'hA5;
        settle();
        chk("w1_gnt0", 32'(gnt0), 32'd1);
        chk("w1_gnt1", 32'(gnt1), 32'd0);
        chk("w1_data", 32'(fifo_data_in), 32'h0A5);
        chk("w1_en_write", 32'(fifo_en_write), 32'd1);
        step();
        req0 = 1'b0;
        chk("w1_count", 32'(count), 32'd1);
        chk("w1_empty", 32'(empty), 32'd0);
        settle();
        chk("idle_data_zero", 32'(fifo_data_in), 32'd0);

        // round robin tie from reset
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h0A; data1 = 8'h1B;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("rr_gnt0", 32'(gnt0), 32'((i % 2) == 0));
            chk("rr_gnt1", 32'(gnt1), 32'((i % 2) == 1));
            chk("rr_data", 32'(fifo_data_in), ((i % 2) == 0) ? 32'h0A : 32'h1B);
            step();
        end
        req1 = 1'b0;
        chk("rr_count4", 32'(count), 32'd4);

        // fill to full, overflow, then read
        for (int i = 0; i < 12; i++) step();
        req0 = 1'b0;
        chk("fill_count16", 32'(count), 32'd16);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ovf_clear", 32'(ovf_err), 32'd0);
        req1 = 1'b1;
        settle();
        chk("full_gnt1", 32'(gnt1), 32'd0);
        chk("full_en_write", 32'(fifo_en_write), 32'd0);
        step();
        req1 = 1'b0;
        chk("full_ovf", 32'(ovf_err), 32'd1);
        chk("full_count_hold", 32'(count), 32'd16);
        rd_req = 1'b1;
        settle();
        chk("full_en_read", 32'(fifo_en_read), 32'd1);
        chk("full_rd_valid_pre", 32'(rd_valid), 32'd0);
        step();
        rd_req = 1'b0;
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_count15", 32'(count), 32'd15);
        chk("rd_not_full", 32'(full), 32'd0);
        step();
        chk("rd_valid_drop", 32'(rd_valid), 32'd0);

        // full with simultaneous read: write refused
        write_n(1);
        chk("refill_full", 32'(full), 32'd1);
        req0 = 1'b1; rd_req = 1'b1;
        settle();
        chk("wtf_gnt0", 32'(gnt0), 32'd0);
        chk("wtf_en_read", 32'(fifo_en_read), 32'd1);
        step();
        idle_inputs();
        chk("wtf_count15", 32'(count), 32'd15);

        // underflow
        do_reset();
        rd_req = 1'b1;
        settle();
        chk("udf_en_read", 32'(fifo_en_read), 32'd0);
        step();
        rd_req = 1'b0;
        chk("udf_err", 32'(udf_err), 32'd1);
        chk("udf_rd_valid", 32'(rd_valid), 32'd0);
        chk("udf_count", 32'(count), 32'd0);

        // simultaneous write and read at count 5
        do_reset();
        write_n(5);
        chk("sim_count5", 32'(count), 32'd5);
        req0 = 1'b1; rd_req = 1'b1;
        settle();
        chk("sim_gnt0", 32'(gnt0), 32'd1);
        chk("sim_en_read", 32'(fifo_en_read), 32'd1);
        step();
        idle_inputs();
        chk("sim_count_hold", 32'(count), 32'd5);
        chk("sim_rd_valid", 32'(rd_valid), 32'd1);

        // last grant only moves on granted cycles
        do_reset();
        req1 = 1'b1;
        step();
        req0 = 1'b1;
        settle();
        chk("hist_tie_after_p1", 32'(gnt0), 32'd1);
        step();
        req1 = 1'b0;
        step();
        req0 = 1'b0;
        step();
        req0 = 1'b1; req1 = 1'b1;
        settle();
        chk("hist_tie_after_idle", 32'(gnt1), 32'd1);
        step();
        idle_inputs();
        chk("hist_count4", 32'(count), 32'd4);

        // flush with errors set at count 9
        do_reset();
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        write_n(9);
        chk("fl_pre_count9", 32'(count), 32'd9);
        chk("fl_pre_udf", 32'(udf_err), 32'd1);
        flush = 1'b1; req0 = 1'b1; rd_req = 1'b1;
        settle();
        chk("fl_gnt0_blocked", 32'(gnt0), 32'd0);
        chk("fl_en_read_blocked", 32'(fifo_en_read), 32'd0);
        step();
        flush = 1'b0; rd_req = 1'b0;
        chk("fl_count0", 32'(count), 32'd0);
        chk("fl_udf_clear", 32'(udf_err), 32'd0);
        chk("fl_ovf_clear", 32'(ovf_err), 32'd0);
        chk("fl_fifo_reset", 32'(fifo_reset), 32'd1);
        chk("fl_empty", 32'(empty), 32'd1);
        settle();
        chk("fl_gnt0_during_fifo_reset", 32'(gnt0), 32'd0);
        step();
        chk("fl_fifo_reset_drop", 32'(fifo_reset), 32'd0);
        chk("fl_req_not_queued", 32'(count), 32'd0);
        settle();
        chk("fl_gnt0_resume", 32'(gnt0), 32'd1);
        req0 = 1'b0;

        // async reset in the middle of a read
        do_reset();
        write_n(2);
        rd_req = 1'b1;
        settle();
        chk("ar_en_read", 32'(fifo_en_read), 32'd1);
        reset = 1'b1;
        #1;
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_empty", 32'(empty), 32'd1);
        chk("ar_full", 32'(full), 32'd0);
        chk("ar_fifo_reset", 32'(fifo_reset), 32'd1);
        chk("ar_en_read_off", 32'(fifo_en_read), 32'd0);
        step();
        rd_req = 1'b0;
        chk("ar_rd_valid", 32'(rd_valid), 32'd0);
        reset = 1'b0;
        step();
        chk("ar_rd_valid_after", 32'(rd_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width of both producer ports and the FIFO write data.
REQ-002 Parameter DEPTH, default 16, SHALL set the FIFO entry count tracked by the controller.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, SHALL be the asynchronous active-high reset.
REQ-005 Ports req0 and req1, input, 1 each, SHALL be the producer write requests.
REQ-006 Ports data0 and data1, input, WIDTH each, SHALL carry the producer write data.
REQ-007 Ports gnt0 and gnt1, output, 1 each, SHALL be the combinational one-hot write grants.
REQ-008 Port rd_req, input, 1, SHALL be the consumer read request.
REQ-009 Port rd_valid, output, 1, SHALL mark the cycle in which the FIFO data_out holds popped data.
REQ-010 Port flush, input, 1, SHALL be the synchronous clear request.
REQ-011 Ports fifo_data_in (WIDTH), fifo_en_write (1), fifo_en_read (1), fifo_reset (1), outputs, SHALL drive the FIFO datapath.
REQ-012 Ports count (clog2(DEPTH)+1), full (1), empty (1), ovf_err (1), udf_err (1), outputs, SHALL report occupancy and sticky errors.

Function
REQ-013 Write eligibility: a write SHALL be granted only when full is 0; full SHALL be 1 exactly when count == DEPTH.
REQ-014 Single requester, eligible: its grant SHALL assert in the same cycle.
REQ-015 Both requesting, eligible: grant SHALL go to the requester not granted last (round-robin); last_gnt SHALL update only on a granted cycle.
REQ-016 fifo_en_write SHALL equal gnt0|gnt1; fifo_data_in SHALL be data of the granted requester, else all zero.
REQ-017 fifo_en_read SHALL equal rd_req & ~empty; empty SHALL be 1 exactly when count == 0.
REQ-018 rd_valid SHALL be fifo_en_read registered by one cycle, matching the FIFO's one-cycle read latency.
REQ-019 count: +1 on write only, -1 on read only, unchanged on simultaneous write and read or neither; never outside 0..DEPTH.
REQ-020 Full with simultaneous rd_req: writes SHALL still be refused that cycle (no write-through-on-full).
REQ-021 ovf_err SHALL set (sticky) when req0 or req1 is high while full; udf_err SHALL set (sticky) when rd_req is high while empty.
REQ-022 flush: at the next edge count, last_gnt, ovf_err, udf_err, rd_valid SHALL clear; fifo_reset SHALL pulse high for exactly the following cycle; grants and fifo_en_read SHALL be 0 while flush or fifo_reset is high.
REQ-023 Requests SHALL be ignored, not queued, while fifo_reset is high.

Reset
REQ-024 On reset assertion, count = 0, empty = 1, full = 0, rd_valid = 0, ovf_err = 0, udf_err = 0, last_gnt = producer 1 (so producer 0 wins first tie), immediately and asynchronously.
REQ-025 fifo_reset SHALL be high while reset is high and for one cycle after deassertion, so the synchronously-reset FIFO pointers clear.
REQ-026 Reset asserted mid-transfer SHALL abandon the in-flight read; no rd_valid after reset.

Structure
REQ-027 A shared package SHALL hold DEPTH/WIDTH defaults, the count-width constant, and the last_gnt encoding.
REQ-028 One sub-module, rr_arb2 (two-way round-robin arbiter with enable and last-grant register), SHALL be instantiated; counter, flags and read timing SHALL stay in the top.
REQ-029 The block SHALL instantiate no storage; it connects to the existing 16x8 FIFO.

Verification
REQ-030 Reset, then req0=1 data0=8'hA5 one cycle -> gnt0=1, fifo_data_in=8'hA5, count=1, empty=0.
REQ-031 req0=req1=1 for 4 cycles from reset -> grants 0,1,0,1; count=4.
REQ-032 16 writes then req1=1 -> full=1, gnt1=0, ovf_err=1, count stays 16; then rd_req=1 -> rd_valid next cycle, count=15.
REQ-033 rd_req=1 when empty -> fifo_en_read=0, udf_err=1, rd_valid=0.
REQ-034 count=5, simultaneous req0 and rd_req -> count stays 5, gnt0=1, rd_valid next cycle.
REQ-035 count=9 with errors set, flush=1 -> next cycle count=0, errors=0, fifo_reset=1 one cycle; async reset mid-read -> all outputs per REQ-024 without clock edge.
